// File: rtl/sound_out_stage.sv
// Audio output stage: box-average, fractional-rate decimation, DC blocker,
// click-free gain ramp and output saturation, duplicated to both channels.
module sound_out_stage #(
  parameter int CLK_HZ   = 40000000,
  parameter int OUT_HZ   = 48000,
  parameter int AVG_LOG2 = 9,
  parameter int DC_SHIFT = 10,
  parameter int DC_EN    = 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               paused,
  input  logic               mute,
  input  logic signed [15:0] sample_in,
  input  logic               clip_clr,
  output logic signed [15:0] sample_l,
  output logic signed [15:0] sample_r,
  output logic               sample_stb,
  output logic               clip_seen
);

  localparam logic [26:0] OUT_INC = 27'(OUT_HZ);
  localparam logic [26:0] CLK_DEC = 27'(CLK_HZ);

  // Averager
  logic signed [25:0]   sum_reg;
  logic signed [25:0]   sum_next;
  logic [AVG_LOG2-1:0]  win_cnt_reg;
  logic signed [15:0]   avg_reg;

  // Rate generator
  logic [26:0] acc_reg;
  logic [26:0] acc_sum;
  logic        tick_next;
  logic        tick_reg;

  // Stage 1: DC blocker and gain ramp
  logic signed [15:0] x1_reg;
  logic signed [17:0] y1_reg;
  logic signed [17:0] y_reg;
  logic signed [17:0] y_next;
  logic signed [19:0] dc_raw;
  logic signed [17:0] dc_sat;
  logic [8:0]         gain_reg;
  logic [8:0]         gain_next;
  logic               v1_reg;

  // Stage 2: gain multiply
  logic signed [27:0] y_ext;
  logic signed [27:0] g_ext;
  logic signed [26:0] prod_reg;
  logic               v2_reg;

  // Stage 3: output saturation
  logic signed [26:0] s_full;
  logic signed [15:0] sat_val;
  logic               sat_hit;
  logic signed [15:0] out_reg;
  logic               stb_reg;
  logic               clip_reg;

  assign sum_next = sum_reg + 26'(sample_in);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_reg     <= '0;
      win_cnt_reg <= '0;
      avg_reg     <= '0;
    end else begin
      win_cnt_reg <= win_cnt_reg + AVG_LOG2'(1);
      if (&win_cnt_reg) begin
        avg_reg <= 16'(sum_next >>> AVG_LOG2);
        sum_reg <= '0;
      end else begin
        sum_reg <= sum_next;
      end
    end
  end

  assign acc_sum   = acc_reg + OUT_INC;
  assign tick_next = (acc_sum >= CLK_DEC);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      acc_reg  <= tick_next ? (acc_sum - CLK_DEC) : acc_sum;
      tick_reg <= tick_next;
    end
  end

  // Widened to 20 bits so the un-clamped sum cannot wrap before saturation.
  assign dc_raw = 20'(avg_reg) - 20'(x1_reg) + 20'(y1_reg) - 20'(y1_reg >>> DC_SHIFT);

  always_comb begin
    dc_sat = dc_raw[17:0];
    if (dc_raw > 20'sd131071) begin
      dc_sat = 18'sh1FFFF;
    end else if (dc_raw < -20'sd131072) begin
      dc_sat = 18'sh20000;
    end
  end

  assign y_next = (DC_EN != 0) ? dc_sat : 18'(avg_reg);

  always_comb begin
    gain_next = gain_reg;
    if (paused | mute) begin
      if (gain_reg != 9'd0) begin
        gain_next = gain_reg - 9'd1;
      end
    end else if (gain_reg != 9'd256) begin
      gain_next = gain_reg + 9'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x1_reg   <= '0;
      y1_reg   <= '0;
      y_reg    <= '0;
      gain_reg <= '0;
      v1_reg   <= 1'b0;
    end else begin
      v1_reg <= tick_reg;
      if (tick_reg) begin
        y_reg    <= y_next;
        y1_reg   <= y_next;
        x1_reg   <= avg_reg;
        gain_reg <= gain_next;
      end
    end
  end

  assign y_ext = 28'(y_reg);
  assign g_ext = {19'd0, gain_reg};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prod_reg <= '0;
      v2_reg   <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        prod_reg <= 27'(y_ext * g_ext);
      end
    end
  end

  assign s_full = prod_reg >>> 8;

  always_comb begin
    sat_val = s_full[15:0];
    sat_hit = 1'b0;
    if (s_full > 27'sd32767) begin
      sat_val = 16'sh7FFF;
      sat_hit = 1'b1;
    end else if (s_full < -27'sd32768) begin
      sat_val = 16'sh8000;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_reg  <= '0;
      stb_reg  <= 1'b0;
      clip_reg <= 1'b0;
    end else begin
      stb_reg <= v2_reg;
      if (v2_reg) begin
        out_reg <= sat_val;
      end
      // A saturating strobe outranks a simultaneous clear.
      if (v2_reg && sat_hit) begin
        clip_reg <= 1'b1;
      end else if (clip_clr) begin
        clip_reg <= 1'b0;
      end
    end
  end

  assign sample_l   = out_reg;
  assign sample_r   = out_reg;
  assign sample_stb = stb_reg;
  assign clip_seen  = clip_reg;

endmodule

// File: tb/tb_sound_out_stage.sv
// Directed bench for sound_out_stage using scaled rates (100 Hz clock, 22 Hz
// output, 4-clock window) so fades and DC decay fit in a short run.
module tb_sound_out_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        paused0, mute0, clip_clr0;
  logic        paused1, mute1, clip_clr1;
  logic [15:0] in0, in1;
  logic [15:0] l0, r0, l1, r1;
  logic        stb0, stb1, clip0, clip1;

  int checks   = 0;
  int errors   = 0;
  int timeouts = 0;
  int cyc      = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  sound_out_stage #(
    .CLK_HZ(100), .OUT_HZ(22), .AVG_LOG2(2), .DC_SHIFT(4), .DC_EN(0)
  ) u_dut0 (
    .clk_sys(clk), .reset(reset), .paused(paused0), .mute(mute0),
    .sample_in(in0), .clip_clr(clip_clr0),
    .sample_l(l0), .sample_r(r0), .sample_stb(stb0), .clip_seen(clip0)
  );

  sound_out_stage #(
    .CLK_HZ(100), .OUT_HZ(22), .AVG_LOG2(2), .DC_SHIFT(4), .DC_EN(1)
  ) u_dut1 (
    .clk_sys(clk), .reset(reset), .paused(paused1), .mute(mute1),
    .sample_in(in1), .clip_clr(clip_clr1),
    .sample_l(l1), .sample_r(r1), .sample_stb(stb1), .clip_seen(clip1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns after the negedge where the selected strobe is seen; gap is the
  // number of clocks since the call.
  task automatic wait_stb(input bit sel, output int gap);
    gap = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      gap++;
      if ((sel ? stb1 : stb0) === 1'b1) return;
    end
    checks++;
    errors++;
    timeouts++;
    $display("FAIL strobe_timeout: observed=no strobe expected=strobe within 50 clocks (dut%0d)", sel);
    if (timeouts > 10) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "too many strobe timeouts");
    end
  endtask

  // Change dut1's input at a window boundary so no partial average appears.
  task automatic step1(input logic [15:0] v);
    for (int i = 0; i < 8; i++) begin
      if (cyc % 4 == 0) break;
      @(negedge clk);
    end
    in1 = v;
  endtask

  initial begin
    int gap;
    int cnt;
    int y;
    logic [15:0] ym;

    reset = 1'b1;
    paused0 = 1'b0; mute0 = 1'b0; clip_clr0 = 1'b0;
    paused1 = 1'b0; mute1 = 1'b0; clip_clr1 = 1'b0;
    in0 = 16'h1000;
    in1 = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_l0", l0, 0);
    check("reset_stb0", stb0, 0);
    check("reset_clip0", clip0, 0);
    check("reset_l1", l1, 0);
    reset = 1'b0;

    // Fade-in from silence, gap between strobes always 4 or 5 clocks
    for (int n = 1; n <= 300; n++) begin
      wait_stb(0, gap);
      check($sformatf("fade_l_%0d", n), l0, ((n < 256) ? n : 256) * 16);
      check($sformatf("fade_r_%0d", n), r0, ((n < 256) ? n : 256) * 16);
      if (n >= 2) check($sformatf("gap_%0d", n), (gap == 4 || gap == 5), 1);
      $display("fade strobe %0d: l=%h r=%h gap=%0d", n, l0, r0, gap);
    end
    @(negedge clk);
    check("stb_width", stb0, 0);

    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (stb0) cnt++;
    end
    check("rate_per_100clk", cnt, 22);

    // Pause: fade to zero, then hold
    paused0 = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      wait_stb(0, gap);
      check($sformatf("pause_down_%0d", k), l0, ((k < 256) ? (256 - k) : 0) * 16);
      $display("pause strobe %0d: l=%h", k, l0);
    end
    paused0 = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      wait_stb(0, gap);
      check($sformatf("resume_up_%0d", k), l0, k * 16);
    end
    paused0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_stb(0, gap);
      check($sformatf("reverse_down_%0d", k), l0, (120 - k) * 16);
    end
    paused0 = 1'b0;
    wait_stb(0, gap);
    check("unpause_at_100", l0, 16'h0650);
    mute0 = 1'b1;
    wait_stb(0, gap);
    check("mute_step", l0, 16'h0640);
    mute0 = 1'b0;
    wait_stb(0, gap);
    check("unmute_step", l0, 16'h0650);
    $display("pause/mute reversal: l=%h", l0);

    // DC blocker step response on dut1 (full gain by now)
    step1(16'h4000);
    for (int i = 0; i < 10; i++) begin
      wait_stb(1, gap);
      if (l1 != 16'h0000) break;
    end
    check("dc_first", l1, 16'h4000);
    y = 16384;
    for (int k = 1; k < 300; k++) begin
      wait_stb(1, gap);
      y = y - (y >>> 4);
      ym = y[15:0];
      check($sformatf("dc_decay_%0d", k), l1, ym);
      if (k < 20) $display("dc strobe %0d: l=%h model=%h", k, l1, ym);
    end
    check("dc_settled", (l1 < 16'd16), 1);

    // Saturation and clip flag
    step1(16'h8000);
    repeat (300) wait_stb(1, gap);
    check("neg_settled", l1, 16'h0000);
    check("clip_from_neg_step", clip1, 1);
    clip_clr1 = 1'b1;
    wait_stb(1, gap);
    clip_clr1 = 1'b0;
    check("clip_cleared", clip1, 0);
    check("clear_strobe_value", l1, 16'h0000);

    step1(16'h7FFF);
    for (int i = 0; i < 10; i++) begin
      wait_stb(1, gap);
      if (l1 != 16'h0000) break;
    end
    check("sat_pos", l1, 16'h7FFF);
    check("sat_pos_r", r1, 16'h7FFF);
    check("clip_set", clip1, 1);
    $display("positive clip: l=%h clip=%b", l1, clip1);
    repeat (300) wait_stb(1, gap);
    check("pos_settled", (l1 < 16'd16), 1);

    clip_clr1 = 1'b1;
    step1(16'h8000);
    for (int i = 0; i < 10; i++) begin
      wait_stb(1, gap);
      if (l1[15]) break;
    end
    check("sat_neg", l1, 16'h8000);
    check("clip_set_wins", clip1, 1);
    clip_clr1 = 1'b0;
    $display("negative clip with clear: l=%h clip=%b", l1, clip1);

    // Reset with a tick in flight
    wait_stb(0, gap);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_l0", l0, 0);
    check("rst_r0", r0, 0);
    check("rst_stb0", stb0, 0);
    check("rst_clip1", clip1, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_no_stb_a", stb0, 0);
    @(negedge clk);
    check("rst_no_stb_b", stb0, 0);
    wait_stb(0, gap);
    check("rst_refade", l0, 16'h0010);
    $display("after reset: l=%h", l0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
